// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - Posit format definitions shared by the PPU extraction and construction stages
//
// Contents:
//   posit_format_e           supported posit formats (all with ES = 2)
//   posit_width / exp_bits   N and ES of a format
//   posit_max_k / min_k      largest and smallest regime value that still encodes
//   POSITxx_NAR / _ZERO      special bit patterns per format
//   posit_fields_t           decoded posit fields, sized for the widest format

package posit_pkg;

    typedef enum logic [1:0] {
        POSIT8_ES2  = 2'd0,
        POSIT16_ES2 = 2'd1,
        POSIT32_ES2 = 2'd2
    } posit_format_e;

    localparam int P_N_MAX  = 32;
    localparam int P_ES_MAX = 2;
    localparam int P_RS_MAX = 5;

    localparam logic [7:0]  POSIT8_NAR   = 8'h80;
    localparam logic [7:0]  POSIT8_ZERO  = 8'h00;
    localparam logic [15:0] POSIT16_NAR  = 16'h8000;
    localparam logic [15:0] POSIT16_ZERO = 16'h0000;
    localparam logic [31:0] POSIT32_NAR  = 32'h8000_0000;
    localparam logic [31:0] POSIT32_ZERO = 32'h0000_0000;

    function automatic int posit_width(input posit_format_e fmt);
        case (fmt)
            POSIT16_ES2: return 16;
            POSIT32_ES2: return 32;
            default:     return 8;
        endcase
    endfunction

    function automatic int exp_bits(input posit_format_e fmt);
        case (fmt)
            default: return 2;
        endcase
    endfunction

    function automatic int posit_max_k(input posit_format_e fmt);
        return posit_width(fmt) - 2;
    endfunction

    function automatic int posit_min_k(input posit_format_e fmt);
        return -(posit_width(fmt) - 2);
    endfunction

    // Sized for the widest format; narrower formats use the low bits.
    typedef struct packed {
        logic                       sign;
        logic signed [P_RS_MAX+1:0] k;
        logic [P_ES_MAX-1:0]        exp;
        logic [P_N_MAX-1:0]         mant;
        logic                       sticky;
        logic                       nar;
        logic                       zero;
    } posit_fields_t;

endpackage

// File: rtl/posit_round.sv
// rtl/posit_round.sv - Rounds and clamps an (N-1)-bit posit magnitude
//
// Ports:
//   i_mag     N-1  unrounded magnitude (regime, exponent, fraction)
//   i_guard   1    first discarded bit
//   i_sticky  1    OR of all bits below the guard
//   o_mag     N-1  rounded magnitude, never zero and never wrapping past maxpos
//
// Build option: POSIT_CONSTRUCTION_RNE_EN selects round-to-nearest-even;
// without it the magnitude is truncated and guard/sticky are ignored.

module posit_round #(
    parameter int N = 8
) (
    input  logic [N-2:0] i_mag,
    input  logic         i_guard,
    input  logic         i_sticky,
    output logic [N-2:0] o_mag
);

    localparam logic [N-2:0] MAG_MAX = '1;
    localparam logic [N-2:0] MAG_MIN = (N-1)'(1);

    logic [N-2:0] w_mag;

`ifdef POSIT_CONSTRUCTION_RNE_EN
    logic         w_inc;
    logic [N-1:0] w_sum;

    assign w_inc = i_guard & (i_sticky | i_mag[0]);
    assign w_sum = {1'b0, i_mag} + {{(N-1){1'b0}}, w_inc};
    // A carry into bit N-1 would turn the magnitude into the NaR pattern.
    assign w_mag = w_sum[N-1] ? MAG_MAX : w_sum[N-2:0];
`else
    logic w_unused_round;

    assign w_unused_round = i_guard ^ i_sticky;
    assign w_mag          = i_mag;
`endif

    // A nonzero value must never collapse to the zero encoding.
    assign o_mag = (w_mag == '0) ? MAG_MIN : w_mag;

endmodule

// File: rtl/posit_construction.sv
// rtl/posit_construction.sv - Two-stage pipelined posit encoder (fields -> N-bit posit)
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   in_valid_i / in_ready_o  input field handshake
//   sign_i, k_i, exp_i       sign, signed regime value, exponent field
//   mant_i                   mantissa with hidden bit at MSB
//   sticky_i                 OR of fraction bits discarded upstream
//   nar_i, zero_i            force NaR / zero
//   out_valid_o/out_ready_i  result handshake
//   result_o                 encoded posit
//
// Build option: POSIT_CONSTRUCTION_RNE_EN enables round-to-nearest-even;
// default build truncates. Latency is 2 cycles either way.

module posit_construction
    import posit_pkg::*;
#(
    parameter posit_format_e pFormat = posit_format_e'(0),
    localparam int N  = posit_width(pFormat),
    localparam int ES = exp_bits(pFormat),
    localparam int RS = $clog2(N)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                sign_i,
    input  logic signed [RS+1:0] k_i,
    input  logic [ES-1:0]       exp_i,
    input  logic [N-1:0]        mant_i,
    input  logic                sticky_i,
    input  logic                nar_i,
    input  logic                zero_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [N-1:0]        result_o
);

    localparam int KW  = RS + 2;
    // Working field is wide enough that the longest in-range regime shift
    // never pushes exponent or fraction bits off the bottom.
    localparam int W   = 3 * N;
    localparam int PAD = W - 2 - ES - (N - 1);

    localparam logic signed [KW-1:0] K_MAX = KW'(posit_max_k(pFormat));
    localparam logic signed [KW-1:0] K_MIN = KW'(posit_min_k(pFormat));
    localparam logic [N-1:0] NAR_PATTERN   = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-2:0] MAG_MAX       = '1;
    localparam logic [N-2:0] MAG_MIN       = (N-1)'(1);

    // Handshake
    logic w_s1_ready;
    logic w_in_fire;
    logic w_s1_fire;

    // Stage 1 combinational
    logic signed [W-1:0] w_start;
    logic signed [W-1:0] w_field;
    logic [KW-1:0]       w_shamt;
    logic [N-2:0]        w_mag;
    logic                w_maxpos;
    logic                w_minpos;
    logic                w_unused_hidden;

    // Stage 1 registers
    logic                r_s1_valid;
    logic                r_s1_sign;
    logic [N-2:0]        r_s1_mag;
    logic                r_s1_maxpos;
    logic                r_s1_minpos;
    logic                r_s1_nar;
    logic                r_s1_zero;
    logic                w_s1_guard;
    logic                w_s1_sticky;

    // Stage 2
    logic [N-2:0]        w_round_mag;
    logic [N-2:0]        w_mag_sel;
    logic [N-1:0]        w_pos;
    logic [N-1:0]        w_final;
    logic                r_s2_valid;
    logic [N-1:0]        r_result;

    assign w_s1_ready = ~r_s2_valid | out_ready_i;
    assign in_ready_o = ~r_s1_valid | w_s1_ready;
    assign w_in_fire  = in_valid_i & in_ready_o;
    assign w_s1_fire  = r_s1_valid & w_s1_ready;

    // Regime by arithmetic shift: a leading "10" replicates ones for k >= 0
    // (k+1 ones then a zero); a leading "01" replicates zeros for k < 0
    // (-k zeros then a one). For k < 0 the shift is -k-1, i.e. ~k.
    assign w_start = k_i[KW-1] ? {2'b01, exp_i, mant_i[N-2:0], {PAD{1'b0}}}
                               : {2'b10, exp_i, mant_i[N-2:0], {PAD{1'b0}}};
    assign w_shamt = k_i[KW-1] ? ~k_i : k_i;
    assign w_field = w_start >>> w_shamt;
    assign w_mag   = w_field[W-1 -: N-1];

    assign w_maxpos = (k_i > K_MAX);
    assign w_minpos = (k_i < K_MIN);

    assign w_unused_hidden = mant_i[N-1];

`ifdef POSIT_CONSTRUCTION_RNE_EN
    logic w_guard;
    logic w_sticky;
    logic r_s1_guard;
    logic r_s1_sticky;

    assign w_guard  = w_field[W-N];
    assign w_sticky = (|w_field[W-N-1:0]) | sticky_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_guard  <= 1'b0;
            r_s1_sticky <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_guard  <= w_guard;
            r_s1_sticky <= w_sticky;
        end
    end

    assign w_s1_guard  = r_s1_guard;
    assign w_s1_sticky = r_s1_sticky;
`else
    logic w_unused_trunc;

    assign w_unused_trunc = ^{w_field[W-N:0], sticky_i};
    assign w_s1_guard     = 1'b0;
    assign w_s1_sticky    = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
        end else if (in_ready_o) begin
            r_s1_valid <= in_valid_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_sign   <= 1'b0;
            r_s1_mag    <= '0;
            r_s1_maxpos <= 1'b0;
            r_s1_minpos <= 1'b0;
            r_s1_nar    <= 1'b0;
            r_s1_zero   <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_sign   <= sign_i;
            r_s1_mag    <= w_mag;
            r_s1_maxpos <= w_maxpos;
            r_s1_minpos <= w_minpos;
            r_s1_nar    <= nar_i;
            r_s1_zero   <= zero_i;
        end
    end

    posit_round #(
        .N (N)
    ) u_round (
        .i_mag    (r_s1_mag),
        .i_guard  (w_s1_guard),
        .i_sticky (w_s1_sticky),
        .o_mag    (w_round_mag)
    );

    always_comb begin
        w_mag_sel = w_round_mag;
        if (r_s1_maxpos) begin
            w_mag_sel = MAG_MAX;
        end else if (r_s1_minpos) begin
            w_mag_sel = MAG_MIN;
        end
        w_pos   = {1'b0, w_mag_sel};
        w_final = r_s1_sign ? (~w_pos + N'(1)) : w_pos;
        // Specials ignore sign and saturation entirely.
        if (r_s1_nar) begin
            w_final = NAR_PATTERN;
        end else if (r_s1_zero) begin
            w_final = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_valid <= 1'b0;
        end else if (w_s1_ready) begin
            r_s2_valid <= r_s1_valid;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_result <= '0;
        end else if (w_s1_fire) begin
            r_result <= w_final;
        end
    end

    assign out_valid_o = r_s2_valid;
    assign result_o    = r_result;

endmodule
